// File: rtl/deserializer.sv
// Serial-to-parallel converter: rebuilds WIDTH-bit words from an MSB-first bit stream,
// aligned either by reset release or by detecting SYNC_WORD.
module deserializer #(
  parameter int unsigned      WIDTH     = 8,
  parameter bit               USE_SYNC  = 1'b0,
  parameter logic [WIDTH-1:0] SYNC_WORD = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_in,
  input  logic             realign,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             locked
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Only WIDTH-1 history bits are kept: the oldest bit falls out of every new word.
  logic [WIDTH-2:0] sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             locked_q, locked_d;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] nxt_s;

  // Next-state computation for shift path, word counter and alignment FSM
  always_comb begin
    nxt_s        = {sr_q, data_in};
    sr_d         = nxt_s[WIDTH-2:0];
    cnt_d        = cnt_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    locked_d     = locked_q;
    state_d      = state_q;

    if (realign) begin
      if (USE_SYNC) begin
        cnt_d    = CNT_ZERO;
        state_d  = HUNT;
        locked_d = 1'b0;
      end else begin
        // The bit sampled on this edge already counts as the MSB of the new word.
        cnt_d    = CNT_ONE;
        locked_d = 1'b1;
      end
    end else if (USE_SYNC && (state_q == HUNT)) begin
      if (nxt_s == SYNC_WORD) begin
        state_d  = LOCKED;
        locked_d = 1'b1;
        cnt_d    = CNT_ZERO;
      end else begin
        state_d  = HUNT;
      end
    end else begin
      locked_d = 1'b1;
      if (cnt_q == CNT_LAST) begin
        data_out_d   = nxt_s;
        data_valid_d = 1'b1;
        cnt_d        = CNT_ZERO;
      end else begin
        cnt_d        = cnt_q + CNT_ONE;
      end
    end
  end

  // State registers with synchronous reset taking priority over all inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q         <= '0;
      cnt_q        <= CNT_ZERO;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      state_q      <= HUNT;
    end else begin
      sr_q         <= sr_d;
      cnt_q        <= cnt_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      locked_q     <= locked_d;
      state_q      <= state_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign locked     = locked_q;

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for deserializer: free-running instance (u_free) and sync-word instance
// (u_sync) share one stimulus stream; each scenario checks the instance it targets.
module tb_deserializer;

  logic       clk;
  logic       rst;
  logic       data_in;
  logic       realign;
  logic [7:0] dout0, dout1;
  logic       valid0, valid1;
  logic       locked0, locked1;

  int n_cmp;
  int n_err;

  deserializer #(.WIDTH(8), .USE_SYNC(1'b0), .SYNC_WORD(8'hA5)) u_free (
    .clk(clk), .rst(rst), .data_in(data_in), .realign(realign),
    .data_out(dout0), .data_valid(valid0), .locked(locked0)
  );

  deserializer #(.WIDTH(8), .USE_SYNC(1'b1), .SYNC_WORD(8'hA5)) u_sync (
    .clk(clk), .rst(rst), .data_in(data_in), .realign(realign),
    .data_out(dout1), .data_valid(valid1), .locked(locked1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic b, input logic r, input logic ra);
    data_in = b;
    rst     = r;
    realign = ra;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [7:0] w;
    w = 8'h9D;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0);
      n_cmp++;
      if (dout0 !== 8'h00) begin n_err++; $display("FAIL reset_dout: got %h want 00", dout0); end
      n_cmp++;
      if (valid0 !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid0); end
      n_cmp++;
      if (locked0 !== 1'b0 || locked1 !== 1'b0) begin
        n_err++; $display("FAIL reset_locked: got %b/%b want 0/0", locked0, locked1);
      end
    end
    for (int i = 0; i < 8; i++) begin
      step(w[7-i], 1'b0, 1'b0);
      n_cmp++;
      if (locked0 !== 1'b1) begin n_err++; $display("FAIL first_locked bit%0d: got %b want 1", i, locked0); end
      if (i < 7) begin
        n_cmp++;
        if (valid0 !== 1'b0 || dout0 !== 8'h00) begin
          n_err++; $display("FAIL first_early bit%0d: got valid=%b dout=%h want 0/00", i, valid0, dout0);
        end
      end else begin
        n_cmp++;
        if (valid0 !== 1'b1 || dout0 !== 8'h9D) begin
          n_err++; $display("FAIL first_word: got valid=%b dout=%h want 1/9d", valid0, dout0);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] s;
    s = 16'h9DBD;
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step(s[15-i], 1'b0, 1'b0);
      n_cmp++;
      if (i == 7) begin
        if (valid0 !== 1'b1 || dout0 !== 8'h9D) begin
          n_err++; $display("FAIL b2b_word0: got valid=%b dout=%h want 1/9d", valid0, dout0);
        end
      end else if (i == 15) begin
        if (valid0 !== 1'b1 || dout0 !== 8'hBD) begin
          n_err++; $display("FAIL b2b_word1: got valid=%b dout=%h want 1/bd", valid0, dout0);
        end
      end else if (i > 7) begin
        if (valid0 !== 1'b0 || dout0 !== 8'h9D) begin
          n_err++; $display("FAIL b2b_gap bit%0d: got valid=%b dout=%h want 0/9d", i, valid0, dout0);
        end
      end else begin
        if (valid0 !== 1'b0) begin
          n_err++; $display("FAIL b2b_pre bit%0d: got valid=%b want 0", i, valid0);
        end
      end
    end
  endtask

  task automatic test_reset_mid_word;
    logic [7:0] a;
    logic [7:0] b;
    a = 8'h9D;
    b = 8'hBD;
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(a[7-i], 1'b0, 1'b0);
      n_cmp++;
      if (valid0 !== 1'b0) begin n_err++; $display("FAIL mid_partial bit%0d: got valid=%b want 0", i, valid0); end
    end
    step(1'b1, 1'b1, 1'b1);
    n_cmp++;
    if (valid0 !== 1'b0 || dout0 !== 8'h00 || locked0 !== 1'b0) begin
      n_err++; $display("FAIL mid_rst: got valid=%b dout=%h locked=%b want 0/00/0", valid0, dout0, locked0);
    end
    for (int i = 0; i < 8; i++) begin
      step(b[7-i], 1'b0, 1'b0);
      n_cmp++;
      if (i < 7) begin
        if (valid0 !== 1'b0 || dout0 !== 8'h00) begin
          n_err++; $display("FAIL mid_early bit%0d: got valid=%b dout=%h want 0/00", i, valid0, dout0);
        end
      end else begin
        if (valid0 !== 1'b1 || dout0 !== 8'hBD) begin
          n_err++; $display("FAIL mid_word: got valid=%b dout=%h want 1/bd", valid0, dout0);
        end
      end
    end
  endtask

  task automatic test_sync_hunt;
    logic [10:0] h;
    logic [7:0]  d;
    h = 11'b110_1010_0101;
    d = 8'h9D;
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 11; i++) begin
      step(h[10-i], 1'b0, 1'b0);
      n_cmp++;
      if (locked1 !== (i == 10) || valid1 !== 1'b0) begin
        n_err++; $display("FAIL hunt bit%0d: got locked=%b valid=%b want %b/0", i, locked1, valid1, (i == 10));
      end
    end
    for (int i = 0; i < 8; i++) begin
      step(d[7-i], 1'b0, 1'b0);
      n_cmp++;
      if (i < 7) begin
        if (valid1 !== 1'b0 || locked1 !== 1'b1 || dout1 !== 8'h00) begin
          n_err++; $display("FAIL hunt_data bit%0d: got valid=%b locked=%b dout=%h want 0/1/00", i, valid1, locked1, dout1);
        end
      end else begin
        if (valid1 !== 1'b1 || dout1 !== 8'h9D) begin
          n_err++; $display("FAIL hunt_word: got valid=%b dout=%h want 1/9d", valid1, dout1);
        end
      end
    end
  endtask

  task automatic test_realign_collision;
    logic [7:0] b;
    logic [7:0] s;
    b = 8'hBD;
    s = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      step(b[7-i], 1'b0, (i == 7));
      n_cmp++;
      if (valid1 !== 1'b0) begin n_err++; $display("FAIL collide_valid bit%0d: got %b want 0", i, valid1); end
    end
    n_cmp++;
    if (dout1 !== 8'h9D || locked1 !== 1'b0) begin
      n_err++; $display("FAIL collide_hold: got dout=%h locked=%b want 9d/0", dout1, locked1);
    end
    for (int i = 0; i < 8; i++) begin
      step(s[7-i], 1'b0, 1'b0);
      n_cmp++;
      if (locked1 !== (i == 7) || valid1 !== 1'b0) begin
        n_err++; $display("FAIL relock bit%0d: got locked=%b valid=%b want %b/0", i, locked1, valid1, (i == 7));
      end
    end
  endtask

  task automatic test_sync_payload;
    logic [15:0] s;
    s = 16'hA59D;
    for (int i = 0; i < 16; i++) begin
      step(s[15-i], 1'b0, 1'b0);
      n_cmp++;
      if (locked1 !== 1'b1) begin n_err++; $display("FAIL payload_locked bit%0d: got %b want 1", i, locked1); end
      n_cmp++;
      if (i == 7) begin
        if (valid1 !== 1'b1 || dout1 !== 8'hA5) begin
          n_err++; $display("FAIL payload_a5: got valid=%b dout=%h want 1/a5", valid1, dout1);
        end
      end else if (i == 15) begin
        if (valid1 !== 1'b1 || dout1 !== 8'h9D) begin
          n_err++; $display("FAIL payload_9d: got valid=%b dout=%h want 1/9d", valid1, dout1);
        end
      end else begin
        if (valid1 !== 1'b0) begin
          n_err++; $display("FAIL payload_gap bit%0d: got valid=%b want 0", i, valid1);
        end
      end
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    rst     = 1'b1;
    data_in = 1'b0;
    realign = 1'b0;
    test_reset();
    test_back_to_back();
    test_reset_mid_word();
    test_sync_hunt();
    test_realign_collision();
    test_sync_payload();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
